// File: rtl/axil_cmdreg_ctrl.sv
// AXI-Lite slave for a 4-word command register file driving a DMA-style engine.
// Optional macro AXIL_SKID_EN lets AW/W be captured while a B response is stalled.
module axil_cmdreg_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_W-1:0]     s_araddr,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  input  logic                  cmd_busy,
  output logic [2*DATA_W-1:0]   cmd_addr,
  output logic                  cmd_start
);

  localparam int STRB_W = DATA_W / 8;

  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
    end
    return r;
  endfunction

  logic                aw_full_q, aw_full_d;
  logic                w_full_q, w_full_d;
  logic [1:0]          aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]   w_strb_q, w_strb_d;
  logic                bvalid_q, bvalid_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_q, start_d;

  logic                aw_rdy, w_rdy, ar_rdy;
  logic                aw_hs, w_hs, ar_hs, commit;
  logic [DATA_W-1:0]   wr_cur, wr_merged, status_w, rd_mux;
  logic                unused_addr;

  assign unused_addr = ^{s_awaddr, s_araddr};
  assign status_w    = {cnt_q, {(DATA_W-CNT_W-1){1'b0}}, cmd_busy};

  always_comb begin
`ifdef AXIL_SKID_EN
    aw_rdy = !aw_full_q;
    w_rdy  = !w_full_q;
`else
    aw_rdy = !aw_full_q && !bvalid_q;
    w_rdy  = !w_full_q && !bvalid_q;
`endif
    ar_rdy = !rvalid_q || s_rready;
    aw_hs  = s_awvalid && aw_rdy;
    w_hs   = s_wvalid && w_rdy;
    ar_hs  = s_arvalid && ar_rdy;
    commit = aw_full_q && w_full_q && (!bvalid_q || s_bready);

    unique case (aw_idx_q)
      2'd0:    wr_cur = ctrl_q;
      2'd2:    wr_cur = lo_q;
      2'd3:    wr_cur = hi_q;
      default: wr_cur = '0;
    endcase
    wr_merged = strb_merge(wr_cur, w_data_q, w_strb_q);

    unique case (s_araddr[3:2])
      2'd0:    rd_mux = ctrl_q;
      2'd1:    rd_mux = status_w;
      2'd2:    rd_mux = lo_q;
      default: rd_mux = hi_q;
    endcase
  end

  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    aw_idx_d  = aw_idx_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    ctrl_d    = ctrl_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;

    // A slot can only be captured while empty and only committed while full,
    // so capture and commit never collide on the same slot.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      cnt_d     = cnt_q + CNT_W'(1);
      unique case (aw_idx_q)
        2'd0: begin
          ctrl_d  = wr_merged & ~{{(DATA_W-1){1'b0}}, 1'b1};
          start_d = w_strb_q[0] && w_data_q[0];
        end
        2'd2:    lo_d = wr_merged;
        2'd3:    hi_d = wr_merged;
        default: ;
      endcase
    end
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s_awaddr[3:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_wdata;
      w_strb_d = s_wstrb;
    end

    if (bvalid_q && s_bready) bvalid_d = 1'b0;
    if (commit)               bvalid_d = 1'b1;

    if (s_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
    end
  end

  // Slot payloads are qualified by the full flags, so they need no reset.
  always_ff @(posedge clk) begin
    aw_idx_q <= aw_idx_d;
    w_data_q <= w_data_d;
    w_strb_q <= w_strb_d;
  end

  assign s_awready = aw_rdy;
  assign s_wready  = w_rdy;
  assign s_arready = ar_rdy;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = 2'b00;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = 2'b00;
  assign cmd_addr  = {hi_q, lo_q};
  assign cmd_start = start_q;

endmodule

// File: tb/tb_axil_cmdreg_ctrl.sv
// Directed bench for axil_cmdreg_ctrl with a read scoreboard and a small register model.
module tb_axil_cmdreg_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                s_awvalid, s_awready;
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_wvalid, s_wready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_bvalid, s_bready;
  logic [1:0]          s_bresp;
  logic                s_arvalid, s_arready;
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_rvalid, s_rready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                cmd_busy;
  logic [2*DATA_W-1:0] cmd_addr;
  logic                cmd_start;

  axil_cmdreg_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .cmd_busy(cmd_busy), .cmd_addr(cmd_addr), .cmd_start(cmd_start)
  );

  int tot_cnt = 0;
  int fail_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  int b_cnt = 0, start_cnt = 0, start_run = 0, start_max = 0;
  always @(negedge clk) begin
    if (s_bvalid && s_bready) b_cnt++;
    if (cmd_start) begin
      start_cnt++;
      start_run++;
      if (start_run > start_max) start_max = start_run;
    end else begin
      start_run = 0;
    end
  end

  logic [DATA_W-1:0] m_ctrl, m_lo, m_hi;
  logic [CNT_W-1:0]  m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tot_cnt++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DATA_W-1:0] status_exp(input logic [CNT_W-1:0] c, input logic busy);
    return {c, {(DATA_W-CNT_W-1){1'b0}}, busy};
  endfunction

  function automatic logic [DATA_W-1:0] bytes_upd(input logic [DATA_W-1:0] o, input logic [DATA_W-1:0] n,
                                                  input logic [DATA_W/8-1:0] s);
    logic [DATA_W-1:0] r;
    r = o;
    for (int k = 0; k < DATA_W/8; k++) if (s[k]) r[k*8 +: 8] = n[k*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_lo = '0; m_hi = '0; m_cnt = '0;
  endtask

  task automatic model_write(input logic [1:0] idx, input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s);
    case (idx)
      2'd0: begin m_ctrl = bytes_upd(m_ctrl, d, s); m_ctrl[0] = 1'b0; end
      2'd2: m_lo = bytes_upd(m_lo, d, s);
      2'd3: m_hi = bytes_upd(m_hi, d, s);
      default: ;
    endcase
    m_cnt = m_cnt + 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw_w(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s);
    bit aw_done, w_done, aw_hs, w_hs;
    int t;
    aw_done = 0; w_done = 0; t = 0;
    s_awaddr = a; s_awvalid = 1'b1;
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    while (!(aw_done && w_done) && t < 40) begin
      @(negedge clk);
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      tick();
      if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  s_wvalid = 1'b0; end
      t++;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("aw_w_accept", 64'(aw_done && w_done), 64'd1);
  endtask

  task automatic wait_b(input int b0, input int n);
    int t;
    t = 0;
    while ((b_cnt - b0) < n && t < 40) begin tick(); t++; end
    chk("b_count", 64'(b_cnt - b0), 64'(n));
  endtask

  task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s);
    int b0;
    b0 = b_cnt;
    send_aw_w(a, d, s);
    model_write(a[3:2], d, s);
    wait_b(b0, 1);
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] expv, input string tag);
    bit hs, got;
    int t;
    logic [DATA_W-1:0] obs;
    exp_q.push_back(expv);
    s_araddr = a; s_arvalid = 1'b1; hs = 0; t = 0;
    while (!hs && t < 40) begin
      @(negedge clk);
      hs = s_arvalid && s_arready;
      tick();
      t++;
    end
    s_arvalid = 1'b0;
    got = 0; t = 0; obs = '0;
    while (!got && t < 40) begin
      @(negedge clk);
      if (s_rvalid && s_rready) begin got = 1; obs = s_rdata; end
      tick();
      t++;
    end
    chk({tag, "_rvalid"}, 64'(got), 64'd1);
    chk(tag, 64'(obs), 64'(exp_q.pop_front()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, s0, t;
    logic [DATA_W-1:0] held;

    rst = 1'b1; cmd_busy = 1'b0;
    s_awvalid = 1'b0; s_awaddr = '0; s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    s_bready = 1'b1; s_arvalid = 1'b0; s_araddr = '0; s_rready = 1'b1;
    model_reset();
    tick(); tick();
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_rdata", 64'(s_rdata), 64'd0);
    chk("rst_cmd_addr", cmd_addr, 64'd0);
    chk("rst_cmd_start", 64'(cmd_start), 64'd0);
    chk("rst_awready", 64'(s_awready), 64'd1);
    rst = 1'b0;
    tick();

    // Reset while AW is held in its slot and W has not arrived.
    b0 = b_cnt;
    s_awaddr = 4'h8; s_awvalid = 1'b1;
    @(negedge clk);
    chk("mid_aw_accept", 64'(s_awready), 64'd1);
    tick();
    s_awvalid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("mid_rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("mid_rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("mid_rst_awready", 64'(s_awready), 64'd1);
    s_wdata = 32'hffff_ffff; s_wstrb = 4'hf; s_wvalid = 1'b1;
    @(negedge clk);
    tick();
    s_wvalid = 1'b0;
    repeat (5) tick();
    chk("mid_rst_no_b", 64'(b_cnt - b0), 64'd0);
    chk("mid_rst_cmd_addr", cmd_addr, 64'd0);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    model_reset();

    // Byte-strobe merge on CMDADDR_LO.
    axi_write(4'h8, 32'hdeadbeef, 4'hf);
    axi_read(4'h8, 32'hdeadbeef, "lo_full");
    axi_write(4'h8, 32'hfeedface, 4'b0000);
    axi_read(4'h8, 32'hdeadbeef, "lo_strb0000");
    axi_write(4'h8, 32'hfeedface, 4'b0110);
    axi_read(4'h8, 32'hdeedfaef, "lo_strb0110");
    axi_write(4'h8, 32'hfeedface, 4'b1100);
    axi_read(4'h8, 32'hfeedfaef, "lo_strb1100");
    chk("lo_cmd_addr", cmd_addr, {32'h0, 32'hfeedfaef});

    // W leads AW by three cycles.
    b0 = b_cnt;
    s_wdata = 32'h0bad_f00d; s_wstrb = 4'hf; s_wvalid = 1'b1;
    @(negedge clk);
    chk("skew_w_accept", 64'(s_wready), 64'd1);
    tick();
    s_wvalid = 1'b0;
    tick(); tick();
    chk("skew_no_early_b", 64'(s_bvalid), 64'd0);
    s_awaddr = 4'h8; s_awvalid = 1'b1;
    @(negedge clk);
    chk("skew_aw_accept", 64'(s_awready), 64'd1);
    tick();
    s_awvalid = 1'b0;
    @(negedge clk);
    chk("skew_b_not_yet", 64'(s_bvalid), 64'd0);
    tick();
    @(negedge clk);
    chk("skew_b_after_commit", 64'(s_bvalid), 64'd1);
    tick();
    repeat (3) tick();
    chk("skew_one_b", 64'(b_cnt - b0), 64'd1);
    model_write(2'd2, 32'h0bad_f00d, 4'hf);
    chk("skew_cmd_addr_lo", 64'(cmd_addr[31:0]), 64'h0bad_f00d);

    // Start pulse only from CTRL bit0 under wstrb[0].
    s0 = start_cnt; start_max = 0;
    axi_write(4'h0, 32'h1, 4'b0001);
    repeat (3) tick();
    chk("start_pulse_cnt", 64'(start_cnt - s0), 64'd1);
    chk("start_pulse_width", 64'(start_max), 64'd1);
    axi_read(4'h0, 32'h0, "ctrl_bit0_reads0");
    s0 = start_cnt;
    axi_write(4'h0, 32'h301, 4'b0010);
    repeat (3) tick();
    chk("start_no_pulse", 64'(start_cnt - s0), 64'd0);
    axi_read(4'h0, m_ctrl, "ctrl_byte1");
    chk("ctrl_model_byte1", 64'(m_ctrl), 64'h300);

    // B backpressure.
    s_bready = 1'b0;
    b0 = b_cnt;
    send_aw_w(4'hc, 32'hcafe_0001, 4'hf);
    model_write(2'd3, 32'hcafe_0001, 4'hf);
    t = 0;
    while (!s_bvalid && t < 20) begin tick(); t++; end
    repeat (5) begin
      @(negedge clk);
      chk("b_hold", 64'(s_bvalid), 64'd1);
`ifndef AXIL_SKID_EN
      chk("aw_w_blocked", 64'({s_awready, s_wready}), 64'd0);
`endif
      tick();
    end
`ifdef AXIL_SKID_EN
    send_aw_w(4'h8, 32'h1111_2222, 4'hf);
    model_write(2'd2, 32'h1111_2222, 4'hf);
    @(negedge clk);
    chk("b_hold_after_skid", 64'(s_bvalid), 64'd1);
    tick();
`endif
    chk("b_stalled_none", 64'(b_cnt - b0), 64'd0);
    s_bready = 1'b1;
`ifdef AXIL_SKID_EN
    wait_b(b0, 2);
`else
    wait_b(b0, 1);
`endif
    repeat (2) tick();
    chk("bp_cmd_addr", cmd_addr, {m_hi, m_lo});

    // R backpressure.
    s_rready = 1'b0;
    exp_q.push_back(m_hi);
    s_araddr = 4'hc; s_arvalid = 1'b1;
    @(negedge clk);
    tick();
    s_arvalid = 1'b0;
    t = 0;
    while (!s_rvalid && t < 20) begin tick(); t++; end
    held = exp_q[0];
    repeat (5) begin
      @(negedge clk);
      chk("r_hold_valid", 64'(s_rvalid), 64'd1);
      chk("r_hold_data", 64'(s_rdata), 64'(held));
      tick();
    end
    s_rready = 1'b1;
    @(negedge clk);
    chk("r_release_data", 64'(s_rdata), 64'(exp_q.pop_front()));
    tick();
    @(negedge clk);
    chk("r_release_clear", 64'(s_rvalid), 64'd0);
    tick();

    cmd_busy = 1'b1;
    axi_read(4'h4, status_exp(m_cnt, 1'b1), "status_busy");
    cmd_busy = 1'b0;

    // Counter wrap with a STATUS read on the wrapping commit.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    model_reset();
    for (int i = 0; i < 15; i++) axi_write(4'h8, 32'(i), 4'hf);
    b0 = b_cnt;
    send_aw_w(4'h8, 32'h16, 4'hf);
    s_araddr = 4'h4; s_arvalid = 1'b1;
    @(negedge clk);
    chk("wrap_ar_same_cycle", 64'(s_arready), 64'd1);
    tick();
    s_arvalid = 1'b0;
    @(negedge clk);
    chk("wrap_status_pre", 64'(s_rdata), 64'(status_exp(4'd15, 1'b0)));
    tick();
    model_write(2'd2, 32'h16, 4'hf);
    wait_b(b0, 1);
    axi_read(4'h4, status_exp(m_cnt, 1'b0), "wrap_status_after");
    chk("wrap_model_zero", 64'(m_cnt), 64'd0);

    $display("%0d/%0d checks passed", tot_cnt - fail_cnt, tot_cnt);
    $finish;
  end
endmodule
